// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
package edge_det_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   localparam int MAX_SYNC_STAGES = 4;
   localparam int MAX_DEBOUNCE    = 255;

   // Bits needed to hold values 0..value-1; used to size the debounce counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/d_ff_async_en.sv
// Library flop cell: asynchronous active-high reset to RST_VAL, load enable.
module d_ff_async_en #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/edge_det_chan.sv
// One detector channel: synchroniser, debounce filter, edge delay flop and
// the sticky status bit.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEBOUNCE    = 0,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       level,
   output logic       pulse,
   output logic       status
);

   logic sync;
   logic filt;
   logic dly;
   logic rise;
   logic fall;
   logic status_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sync = sig_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] chain_q;
         logic [SYNC_STAGES-1:0] chain_d;
         if (SYNC_STAGES == 1) begin : g_one
            assign chain_d = sig_in;
         end else begin : g_many
            assign chain_d = {chain_q[SYNC_STAGES-2:0], sig_in};
         end
         d_ff_async_en #(.W(SYNC_STAGES), .RST_VAL({SYNC_STAGES{RESET_LEVEL}})) u_chain (
            .clk(clk), .rst(rst), .en(1'b1), .d(chain_d), .q(chain_q)
         );
         assign sync = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   generate
      if (DEBOUNCE == 0) begin : g_nodeb
         d_ff_async_en #(.W(1), .RST_VAL(RESET_LEVEL)) u_filt (
            .clk(clk), .rst(rst), .en(1'b1), .d(sync), .q(filt)
         );
      end else begin : g_deb
         localparam int               CNT_W    = clog2(DEBOUNCE + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             accept;

         // Any sample matching the accepted level restarts the count.
         always_comb begin
            accept = 1'b0;
            cnt_d  = '0;
            if (sync != filt) begin
               if (cnt_q == CNT_LAST) accept = 1'b1;
               else                   cnt_d  = cnt_q + CNT_W'(1);
            end
         end

         d_ff_async_en #(.W(CNT_W), .RST_VAL('0)) u_cnt (
            .clk(clk), .rst(rst), .en(1'b1), .d(cnt_d), .q(cnt_q)
         );
         d_ff_async_en #(.W(1), .RST_VAL(RESET_LEVEL)) u_filt (
            .clk(clk), .rst(rst), .en(accept), .d(sync), .q(filt)
         );
      end
   endgenerate

   d_ff_async_en #(.W(1), .RST_VAL(RESET_LEVEL)) u_dly (
      .clk(clk), .rst(rst), .en(1'b1), .d(filt), .q(dly)
   );

   assign rise  = filt & ~dly;
   assign fall  = ~filt & dly;
   assign pulse = (rise & ((mode == EDGE_RISE) || (mode == EDGE_BOTH)))
                | (fall & ((mode == EDGE_FALL) || (mode == EDGE_BOTH)));
   assign level = filt;

   // Set has priority over clear so an event coinciding with clr survives.
   assign status_d = (status & ~clr) | pulse;

   d_ff_async_en #(.W(1), .RST_VAL(1'b0)) u_status (
      .clk(clk), .rst(rst), .en(1'b1), .d(status_d), .q(status)
   );

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector with per-channel mode, sticky status and a
// single maskable interrupt.
module edge_detector_multi #(
   parameter int   NUM_CH      = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   DEBOUNCE    = 0,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic [0:0]          clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   sig_in,
   input  logic [2*NUM_CH-1:0] mode,
   input  logic [NUM_CH-1:0]   clr,
   input  logic [NUM_CH-1:0]   irq_en,
   output logic [NUM_CH-1:0]   level_out,
   output logic [NUM_CH-1:0]   edge_pulse,
   output logic [NUM_CH-1:0]   status,
   output logic                irq
);

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         edge_det_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .RESET_LEVEL(RESET_LEVEL)
         ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .sig_in(sig_in[i]),
            .mode  (mode[2*i+1:2*i]),
            .clr   (clr[i]),
            .level (level_out[i]),
            .pulse (edge_pulse[i]),
            .status(status[i])
         );
      end
   endgenerate

   assign irq = |(status & irq_en);

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench: an undebounced and a debounced instance, table-driven
// vectors plus hand-written multi-cycle sequences.
module tb_edge_detector_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig0, clr0, en0, lvl0, pls0, st0;
   logic [7:0] mode0;
   logic       irq0;
   logic [3:0] sig3, clr3, en3, lvl3, pls3, st3;
   logic [7:0] mode3;
   logic       irq3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   edge_detector_multi #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE(0), .RESET_LEVEL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .sig_in(sig0), .mode(mode0), .clr(clr0), .irq_en(en0),
      .level_out(lvl0), .edge_pulse(pls0), .status(st0), .irq(irq0)
   );

   edge_detector_multi #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE(3), .RESET_LEVEL(1'b0)) dut3 (
      .clk(clk), .rst(rst), .sig_in(sig3), .mode(mode3), .clr(clr3), .irq_en(en3),
      .level_out(lvl3), .edge_pulse(pls3), .status(st3), .irq(irq3)
   );

   typedef struct {
      logic [3:0] sig;
      logic [7:0] mode;
      logic [3:0] clr;
      logic [3:0] en;
      logic [3:0] e_lvl;
      logic [3:0] e_pls;
      logic [3:0] e_st;
      logic       e_irq;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(input logic [3:0] sig, input logic [7:0] mode,
                               input logic [3:0] clr, input logic [3:0] en,
                               input logic [3:0] e_lvl, input logic [3:0] e_pls,
                               input logic [3:0] e_st, input logic e_irq);
      vec_t v;
      v.sig = sig; v.mode = mode; v.clr = clr; v.en = en;
      v.e_lvl = e_lvl; v.e_pls = e_pls; v.e_st = e_st; v.e_irq = e_irq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(4'hF, 8'b11100100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      tbl[1]  = mk(4'hF, 8'b11100100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      tbl[2]  = mk(4'hF, 8'b11100100, 4'h0, 4'h0, 4'hF, 4'hA, 4'h0, 1'b0);
      tbl[3]  = mk(4'hF, 8'b11100100, 4'h0, 4'h0, 4'hF, 4'h0, 4'hA, 1'b0);
      tbl[4]  = mk(4'hF, 8'b11100100, 4'h0, 4'h1, 4'hF, 4'h0, 4'hA, 1'b0);
      tbl[5]  = mk(4'hF, 8'b11100100, 4'h0, 4'h3, 4'hF, 4'h0, 4'hA, 1'b1);
      tbl[6]  = mk(4'h0, 8'b11100100, 4'h2, 4'h3, 4'hF, 4'h0, 4'h8, 1'b0);
      tbl[7]  = mk(4'h0, 8'b11100100, 4'h0, 4'h3, 4'hF, 4'h0, 4'h8, 1'b0);
      tbl[8]  = mk(4'h0, 8'b11100100, 4'h0, 4'h3, 4'h0, 4'hC, 4'h8, 1'b0);
      tbl[9]  = mk(4'h0, 8'b11100100, 4'h0, 4'h3, 4'h0, 4'h0, 4'hC, 1'b0);
      tbl[10] = mk(4'h0, 8'b11100100, 4'h0, 4'hF, 4'h0, 4'h0, 4'hC, 1'b1);
      tbl[11] = mk(4'h0, 8'b11100100, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
      tbl[12] = mk(4'h0, 8'hFF,       4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

      rst = 1'b1;
      sig0 = '0; clr0 = '0; en0 = 4'hF; mode0 = 8'b11100100;
      sig3 = '0; clr3 = '0; en3 = 4'hF; mode3 = 8'h55;
      #2;
      chk("reset_d0", {lvl0, pls0, st0, irq0}, 0);
      chk("reset_d3", {lvl3, pls3, st3, irq3}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset with inputs at the reset level: nothing may fire.
      for (int k = 0; k < 20; k++) begin
         step();
         chk("idle_d0", {lvl0, pls0, st0, irq0}, 0);
         chk("idle_d3", {lvl3, pls3, st3, irq3}, 0);
      end

      for (int r = 0; r < 13; r++) begin
         sig0 = tbl[r].sig; mode0 = tbl[r].mode; clr0 = tbl[r].clr; en0 = tbl[r].en;
         step();
         chk($sformatf("tbl%0d_level", r),  lvl0, tbl[r].e_lvl);
         chk($sformatf("tbl%0d_pulse", r),  pls0, tbl[r].e_pls);
         chk($sformatf("tbl%0d_status", r), st0,  tbl[r].e_st);
         chk($sformatf("tbl%0d_irq", r),    irq0, tbl[r].e_irq);
      end

      // Set and clear in the same cycle on ch1: set must win.
      sig0 = 4'b0010; clr0 = 4'h0;
      step(); step(); step();
      chk("sc_rise_pulse", pls0, 4'b0010);
      step();
      chk("sc_status_set", st0, 4'b0010);
      sig0 = 4'h0;
      step(); step(); step();
      chk("sc_fall_pulse", pls0, 4'b0010);
      clr0 = 4'b0010;
      step();
      chk("sc_set_wins", st0[1], 1'b1);
      step();
      chk("sc_clear", st0[1], 1'b0);
      clr0 = 4'h0;

      // Debounced instance: 2-cycle glitch on ch0 is rejected.
      en3 = 4'h1; mode3 = 8'h55;
      for (int k = 1; k <= 10; k++) begin
         sig3[0] = (k <= 2);
         step();
         chk($sformatf("glitch2_e%0d", k), {lvl3[0], pls3[0]}, 2'b00);
      end

      // 3-cycle high is accepted: one rising pulse, level back low later.
      for (int k = 1; k <= 10; k++) begin
         sig3[0] = (k <= 3);
         step();
         chk($sformatf("hold3_pulse_e%0d", k), pls3[0], (k == 5));
         chk($sformatf("hold3_level_e%0d", k), lvl3[0], (k >= 5 && k <= 7));
      end
      chk("hold3_status", {st3, irq3}, {4'b0001, 1'b1});

      // Reset in the middle of a debounce count; dut0 input held high through it.
      sig3[0] = 1'b1;
      sig0 = 4'hF; mode0 = 8'h55;
      for (int k = 1; k <= 4; k++) step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_async_d3", {lvl3, pls3, st3, irq3}, 0);
      chk("midrst_async_d0", {lvl0, pls0, st0}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("post_rst_d3_pulse_e%0d", k), pls3, (k == 5) ? 4'h1 : 4'h0);
         chk($sformatf("post_rst_d3_level_e%0d", k), lvl3[0], (k >= 5));
         chk($sformatf("post_rst_d0_pulse_e%0d", k), pls0, (k == 3) ? 4'hF : 4'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
